mul8x8_seg_top: RTL and testbench

//  Unsigned 8x8 sequential shift-add multiplier with a decimal 7-segment readout.
//  A start pulse captures a and b and computes the 16-bit product (max 65025).
//  The product is converted to five BCD digits by double-dabble.

---
 rtl/mul8x8_seg_top_if.sv | 33 +++
 rtl/mul8x8_seg_top.sv | 159 +++++++++++++++
 tb/tb_mul8x8_seg_top.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mul8x8_seg_top_if.sv
// Bus between the 8x8 multiplier/readout block and its user: start, operands, five segment codes.
interface mul8x8_seg_top_if;
    logic       st;
    logic [7:0] a;
    logic [7:0] b;
    logic [6:0] answer0;
    logic [6:0] answer1;
    logic [6:0] answer2;
    logic [6:0] answer3;
    logic [6:0] answer4;

    modport master (
        output st,
        output a,
        output b,
        input  answer0,
        input  answer1,
        input  answer2,
        input  answer3,
        input  answer4
    );

    modport slave (
        input  st,
        input  a,
        input  b,
        output answer0,
        output answer1,
        output answer2,
        output answer3,
        output answer4
    );
endinterface

// File: rtl/mul8x8_seg_top.sv
// Unsigned 8x8 shift-add multiplier, double-dabble to 5 BCD digits, registered 7-segment outputs.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits answer4..answer1.
module mul8x8_seg_top (
    input  logic            clk,
    input  logic            rst,
    mul8x8_seg_top_if.slave bus
);
    localparam int N_DIG = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_BCD,
        S_LOAD
    } state_t;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [N_DIG-1:0][6:0] ANS_RESET = {7'h00, 7'h00, 7'h00, 7'h00, 7'h3F};
`else
    localparam logic [N_DIG-1:0][6:0] ANS_RESET = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
`endif

    state_t                  state_q, state_d;
    logic                    st_q, st_d;
    logic [15:0]             mcand_q, mcand_d;
    logic [7:0]              mplier_q, mplier_d;
    logic [15:0]             acc_q, acc_d;
    logic [19:0]             bcd_q, bcd_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [N_DIG-1:0][6:0]   ans_q, ans_d;

    logic                    st_rise;
    logic [15:0]             acc_sum;
    logic [19:0]             bcd_adj;
    logic [35:0]             dd_shift;
    logic [N_DIG-1:0][6:0]   seg_raw;
    logic [N_DIG-1:0][6:0]   seg_next;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign st_rise = bus.st & ~st_q;
    // Product never exceeds 65025, so the carry out of this add is always zero.
    assign acc_sum  = acc_q + mcand_q;
    // The accumulator doubles as the binary shift source during conversion.
    assign dd_shift = {bcd_adj, acc_q} << 1;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIG; gi++) begin : g_dig
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
            assign seg_raw[gi] = seg7(bcd_q[gi*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_units
                assign seg_next[gi] = seg_raw[gi];
            end else begin : g_upper
                // Blank when this digit and every more significant one are zero.
                assign seg_next[gi] = (bcd_q[4*N_DIG-1 : gi*4] == '0) ? 7'h00 : seg_raw[gi];
            end
`else
            assign seg_next[gi] = seg_raw[gi];
`endif
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        st_d     = bus.st;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ans_d    = ans_q;
        case (state_q)
            S_IDLE: begin
                if (st_rise) begin
                    mcand_d  = {8'h00, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    bcd_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    cnt_d   = '0;
                    state_d = S_BCD;
                end
            end
            S_BCD: begin
                {bcd_d, acc_d} = dd_shift;
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                ans_d   = seg_next;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            st_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ans_q    <= ANS_RESET;
        end else begin
            state_q  <= state_d;
            st_q     <= st_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            ans_q    <= ans_d;
        end
    end

    assign bus.answer0 = ans_q[0];
    assign bus.answer1 = ans_q[1];
    assign bus.answer2 = ans_q[2];
    assign bus.answer3 = ans_q[3];
    assign bus.answer4 = ans_q[4];
endmodule

// File: tb/tb_mul8x8_seg_top.sv
// Bench for mul8x8_seg_top: decimal-arithmetic model checked every cycle plus literal result pins.
module tb_mul8x8_seg_top;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mul8x8_seg_top_if bus ();

    mul8x8_seg_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    localparam logic [34:0] L65025 = {7'h7D, 7'h6D, 7'h3F, 7'h5B, 7'h6D};
    localparam logic [34:0] L10000 = {7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [34:0] L_RST  = {7'h00, 7'h00, 7'h00, 7'h00, 7'h3F};
    localparam logic [34:0] L342   = {7'h00, 7'h00, 7'h4F, 7'h66, 7'h5B};
    localparam logic [34:0] L630   = {7'h00, 7'h00, 7'h7D, 7'h4F, 7'h3F};
    localparam logic [34:0] L35    = {7'h00, 7'h00, 7'h00, 7'h4F, 7'h6D};
    localparam logic [34:0] L143   = {7'h00, 7'h00, 7'h06, 7'h66, 7'h4F};
`else
    localparam logic [34:0] L_RST  = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    localparam logic [34:0] L342   = {7'h3F, 7'h3F, 7'h4F, 7'h66, 7'h5B};
    localparam logic [34:0] L630   = {7'h3F, 7'h3F, 7'h7D, 7'h4F, 7'h3F};
    localparam logic [34:0] L35    = {7'h3F, 7'h3F, 7'h3F, 7'h4F, 7'h6D};
    localparam logic [34:0] L143   = {7'h3F, 7'h3F, 7'h06, 7'h66, 7'h4F};
`endif

    logic [34:0] dut_disp;
    assign dut_disp = {bus.answer4, bus.answer3, bus.answer2, bus.answer1, bus.answer0};

    // Display for a number: decimal digits by division, leading zeros blanked when enabled.
    function automatic logic [34:0] model_disp(input int p);
        logic [34:0] r;
        int v;
        int nd;
        r  = '0;
        v  = p;
        nd = (p >= 10000) ? 5 : (p >= 1000) ? 4 : (p >= 100) ? 3 : (p >= 10) ? 2 : 1;
        for (int i = 0; i < 5; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (i < nd) r[i*7 +: 7] = seg_tbl[v % 10];
`else
            if (nd > 0) r[i*7 +: 7] = seg_tbl[v % 10];
`endif
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [34:0] got, input logic [34:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    endtask

    // Reference: an accepted start yields a*b on the display 25 clocks later.
    logic [34:0] exp_disp = model_disp(0);
    int          busy     = 0;
    int          pend     = 0;
    int          pa, pb;
    logic        st_prev  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     = 0;
            st_prev  = 1'b0;
            exp_disp = model_disp(0);
        end else begin
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    exp_disp = model_disp(pend);
                    $display("txn a=%0d b=%0d product=%0d display=%h", pa, pb, pend, exp_disp);
                end
            end else if (bus.st && !st_prev) begin
                pa   = int'(bus.a);
                pb   = int'(bus.b);
                pend = pa * pb;
                busy = 25;
            end
            st_prev = bus.st;
        end
    end

    always @(negedge clk) begin
        check("cycle", dut_disp, exp_disp);
    end

    task automatic pulse(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        bus.a  = av;
        bus.b  = bv;
        bus.st = 1'b1;
        @(negedge clk);
        bus.st = 1'b0;
        bus.a  = 8'($urandom);
        bus.b  = 8'($urandom);
    endtask

    task automatic run(input logic [7:0] av, input logic [7:0] bv);
        pulse(av, bv);
        repeat (28) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus.st   = 1'b0;
        bus.a    = 8'h00;
        bus.b    = 8'h00;
        repeat (3) @(negedge clk);
        bus.a  = 8'h0F;
        bus.b  = 8'h0F;
        bus.st = 1'b1;
        @(negedge clk);
        bus.st = 1'b0;
        check("reset_state", dut_disp, L_RST);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("st_ignored_in_reset", dut_disp, L_RST);

        run(8'h12, 8'h13);
        check("lit_342", dut_disp, L342);

        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset", dut_disp, L_RST);
        @(negedge clk);
        rst = 1'b0;

        run(8'h23, 8'h12);
        check("lit_630", dut_disp, L630);
        run(8'hFF, 8'hFF);
        check("lit_65025", dut_disp, L65025);
        run(8'h00, 8'hA5);
        check("lit_zero", dut_disp, L_RST);

        // st held high with operands changing: exactly one computation of 5*7.
        @(negedge clk);
        bus.a  = 8'd5;
        bus.b  = 8'd7;
        bus.st = 1'b1;
        repeat (3) @(negedge clk);
        bus.a = 8'd9;
        bus.b = 8'd9;
        repeat (37) @(negedge clk);
        bus.st = 1'b0;
        repeat (2) @(negedge clk);
        check("held_st_35", dut_disp, L35);

        // A second edge during the run is ignored.
        pulse(8'd100, 8'd100);
        repeat (4) @(negedge clk);
        pulse(8'd2, 8'd3);
        repeat (30) @(negedge clk);
        check("ignored_edge_10000", dut_disp, L10000);

        // Reset ten clocks into a run: no partial result, then a fresh run.
        pulse(8'hC8, 8'hC8);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("abort_reset", dut_disp, L_RST);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("no_partial_result", dut_disp, L_RST);
        run(8'h0B, 8'h0D);
        check("lit_143", dut_disp, L143);

        // Random runs; short gaps make some starts land mid-run.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 8'hFF;
                1: rb = 8'h00;
                2: begin ra = 8'hFF; rb = 8'hFF; end
                default: ;
            endcase
            pulse(ra, rb);
            repeat ($urandom_range(3, 32)) @(negedge clk);
        end
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
